// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control sequencer for the 16-bit MIPS datapath.
// Define MIPS_CTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  opcode,
    input  logic [3:0]  funct,
    input  logic        zero_flag,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        i_or_d,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic [1:0]  dest_reg,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        halted,
    output logic        bus_err,
    output logic [3:0]  state_out
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB_R   = 4'd6,
        WB_I   = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        JR     = 4'd11,
        HALT   = 4'd12
    } state_t;

    state_t                state, state_nxt, to_fetch;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  boot, boot_halt, mem_state, timeout, err_set;

    // boot marks the first cycle after reset so a pending halt_req is honoured there too
    assign boot_halt = boot && halt_req;
    assign mem_state = state inside {FETCH, MEM_RD, MEM_WR};
    assign timeout   = mem_state && !mem_ready && wait_cnt == WAIT_CNT_W'(MEM_WAIT_MAX);
    assign to_fetch  = halt_req ? HALT : FETCH;
    assign state_out = state;

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            FETCH:   state_nxt = boot_halt ? HALT : mem_ready ? DECODE : state;
            DECODE:  state_nxt = opcode == 3'd0 ? (funct == 4'd8 ? JR : EXEC_R) :
                                 opcode == 3'd6 ? BRANCH :
                                 opcode inside {3'd2, 3'd3} ? JUMP : EXEC_I;
            EXEC_R:  state_nxt = WB_R;
            EXEC_I:  state_nxt = opcode == 3'd4 ? MEM_RD : opcode == 3'd5 ? MEM_WR : WB_I;
            MEM_RD:  state_nxt = mem_ready ? WB_MEM : state;
            MEM_WR:  state_nxt = mem_ready ? to_fetch : state;
            WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR: state_nxt = to_fetch;
            HALT:    state_nxt = !halt_req && !bus_err ? FETCH : HALT;
            default: begin
                state_nxt = HALT;
                err_set   = 1'b1;
            end
        endcase
        if (timeout) begin
            state_nxt = HALT;
            err_set   = 1'b1;
        end
    end

    always_comb begin
        {pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, dest_reg, mem_to_reg,
         alu_src_a, alu_src_b, alu_op, pc_src, instr_done, halted} = '0;
        case (state)
            FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                ir_wr     = mem_ready && !boot_halt;
                pc_wr     = mem_ready && !boot_halt;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
            end
            EXEC_R: alu_src_a = 1'b1;
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = opcode == 3'd1 ? 2'b10 : 2'b11;
            end
            MEM_RD: begin
                i_or_d = 1'b1;
                mem_rd = 1'b1;
            end
            MEM_WR: begin
                i_or_d     = 1'b1;
                mem_wr     = 1'b1;
                instr_done = mem_ready;
            end
            WB_R: begin
                reg_wr     = 1'b1;
                dest_reg   = 2'b01;
                instr_done = 1'b1;
            end
            WB_I: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
            end
            WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_wr      = zero_flag;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_wr      = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                reg_wr     = opcode == 3'd3;
                dest_reg   = opcode == 3'd3 ? 2'b10 : 2'b00;
                mem_to_reg = opcode == 3'd3 ? 2'b10 : 2'b00;
            end
            JR: begin
                pc_wr      = 1'b1;
                pc_src     = 2'b11;
                instr_done = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
        // reset forces FETCH asynchronously; mask its strobes until rst_n is released
        if (!rst_n)
            {pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, dest_reg, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, instr_done, halted} = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            boot     <= 1'b1;
        end else begin
            state    <= state_nxt;
            wait_cnt <= state_nxt != state ? '0 :
                        mem_state && !mem_ready ? wait_cnt + 1'b1 : wait_cnt;
            bus_err  <= bus_err | err_set;
            boot     <= 1'b0;
        end
    end

`ifdef MIPS_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'(state != HALT);
            instr_cnt <= instr_cnt + 32'(instr_done);
        end
    end
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized instruction streams checked against a path/latency model.
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic       pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr;
        logic [1:0] dest_reg, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       instr_done, halted, bus_err;
        logic [3:0] st;
    } ctl_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [2:0] opcode = '0;
    logic [3:0] funct = '0;
    logic       zero_flag = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
    logic       pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, alu_src_a;
    logic [1:0] dest_reg, mem_to_reg, alu_src_b, alu_op, pc_src;
    logic       instr_done, halted, bus_err;
    logic [3:0] state_out;
    ctl_t       obs;
    int         total = 0, bad = 0;
    int         st_q[$];
    logic       rdy_q[$];

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .halt_req(halt_req), .pc_wr(pc_wr), .ir_wr(ir_wr),
        .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .dest_reg(dest_reg), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
        .halted(halted), .bus_err(bus_err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign obs = {pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, dest_reg, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, pc_src, instr_done, halted, bus_err, state_out};

    // control word the spec prescribes for a state, given the inputs of that cycle
    function automatic ctl_t ref_ctl(int st, logic [2:0] op, logic zf, logic rdy, logic err);
        ctl_t c = '0;
        c.st = 4'(st);
        c.bus_err = err;
        case (st)
            0: begin c.mem_rd = 1; c.alu_src_b = 2'b01; c.alu_op = 2'b11; c.ir_wr = rdy; c.pc_wr = rdy; end
            1: begin c.alu_src_b = 2'b11; c.alu_op = 2'b11; end
            2: c.alu_src_a = 1;
            3: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = op == 3'd1 ? 2'b10 : 2'b11; end
            4: begin c.i_or_d = 1; c.mem_rd = 1; end
            5: begin c.i_or_d = 1; c.mem_wr = 1; c.instr_done = rdy; end
            6: begin c.reg_wr = 1; c.dest_reg = 2'b01; c.instr_done = 1; end
            7: begin c.reg_wr = 1; c.instr_done = 1; end
            8: begin c.reg_wr = 1; c.mem_to_reg = 2'b01; c.instr_done = 1; end
            9: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_wr = zf; c.instr_done = 1; end
            10: begin
                c.pc_wr = 1; c.pc_src = 2'b10; c.instr_done = 1;
                if (op == 3'd3) begin c.reg_wr = 1; c.dest_reg = 2'b10; c.mem_to_reg = 2'b10; end
            end
            11: begin c.pc_wr = 1; c.pc_src = 2'b11; c.instr_done = 1; end
            12: c.halted = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic int latency(logic [2:0] op, logic [3:0] fn);
        if (op == 3'd6 || op == 3'd2 || op == 3'd3 || (op == 3'd0 && fn == 4'd8)) return 3;
        return op == 3'd4 ? 5 : 4;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        ctl_t m = '1;
        if (exp.st == 4'd11) m.alu_src_a = 1'b0;
        total++;
        assert ((obs & m) === (exp & m))
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic add_step(input int st);
        st_q.push_back(st);
        rdy_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic add_mem(input int st, input int waits);
        for (int i = 0; i <= waits; i++) begin
            st_q.push_back(st);
            rdy_q.push_back(i == waits);
        end
    endtask

    // runs one instruction starting in FETCH at posedge+1; ends at posedge+1 after its last cycle
    task automatic run_instr(input logic [2:0] op, input logic [3:0] fn, input logic zf,
                             input int fw, input int mw, input int halt_at, input string tag);
        int done_n = 0, done_at = -1;
        st_q.delete();
        rdy_q.delete();
        opcode = op;
        funct = fn;
        zero_flag = zf;
        add_mem(0, fw);
        add_step(1);
        case (op)
            3'd0: if (fn == 4'd8) add_step(11); else begin add_step(2); add_step(6); end
            3'd6: add_step(9);
            3'd2, 3'd3: add_step(10);
            3'd4: begin add_step(3); add_mem(4, mw); add_step(8); end
            3'd5: begin add_step(3); add_mem(5, mw); end
            default: begin add_step(3); add_step(7); end
        endcase
        foreach (st_q[k]) begin
            mem_ready = rdy_q[k];
            halt_req = halt_at >= 0 && k >= halt_at;
            @(negedge clk);
            check($sformatf("%s step%0d", tag, k), ref_ctl(st_q[k], op, zf, rdy_q[k], 1'b0));
            if (instr_done) begin
                done_n++;
                done_at = k;
            end
            @(posedge clk);
            #1;
        end
        check_int({tag, " done_cnt"}, done_n, 1);
        check_int({tag, " latency"}, done_at + 1,
                  latency(op, fn) + fw + ((op == 3'd4 || op == 3'd5) ? mw : 0));
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b1;
        #12;
        check("reset_outputs", ctl_t'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(3'd0, 4'h0, 1'b0, 0, 0, -1, "add");
        run_instr(3'd4, 4'h7, 1'b0, 0, 3, -1, "lw");
        run_instr(3'd6, 4'h7, 1'b1, 0, 0, -1, "beq_taken");
        run_instr(3'd6, 4'h7, 1'b0, 0, 0, -1, "beq_not");
        run_instr(3'd3, 4'h4, 1'b0, 0, 0, -1, "jal");
        run_instr(3'd2, 4'h1, 1'b0, 1, 0, -1, "j");
        run_instr(3'd0, 4'h8, 1'b0, 0, 0, -1, "jr");
        run_instr(3'd1, 4'h3, 1'b0, 2, 0, -1, "slti");
        run_instr(3'd7, 4'h5, 1'b0, 0, 0, -1, "addi");
        run_instr(3'd5, 4'h2, 1'b0, 0, 2, -1, "sw");
        run_instr(3'd4, 4'h1, 1'b0, 15, 15, -1, "lw_max_wait");
        run_instr(3'd5, 4'h1, 1'b0, 15, 15, -1, "sw_max_wait");

        for (int n = 0; n < 60; n++)
            run_instr(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 4), -1, $sformatf("rand%0d", n));

        // halt raised mid-instruction: it completes, then parks in HALT
        run_instr(3'd0, 4'h2, 1'b0, 0, 0, 2, "halt_add");
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halted%0d", i), ref_ctl(12, 3'd0, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        halt_req = 1'b0;
        @(negedge clk);
        check("halt_release", ref_ctl(12, 3'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        run_instr(3'd7, 4'h0, 1'b0, 0, 0, -1, "after_halt");

        // asynchronous reset in WB_R: no register write survives
        opcode = 3'd0;
        funct = 4'h0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_abort_wb", ref_ctl(6, 3'd0, 1'b0, 1'b1, 1'b0));
        #1 rst_n = 1'b0;
        #1 check("abort_reset", ctl_t'(0));

        // halt_req held while leaving reset goes straight to HALT
        halt_req = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("boot_no_fetch", ref_ctl(0, 3'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("boot_halt", ref_ctl(12, 3'd0, 1'b0, 1'b0, 1'b0));
        halt_req = 1'b0;
        @(posedge clk);
        #1;
        run_instr(3'd6, 4'h0, 1'b1, 0, 0, -1, "post_boot");

        // fetch timeout: 15 tolerated wait cycles, error on the next unanswered one
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("fetch_wait%0d", i), ref_ctl(0, 3'd6, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("bus_err_halt%0d", i), ref_ctl(12, 3'd6, 1'b0, 1'b0, 1'b1));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1 check("bus_err_reset", ctl_t'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(3'd4, 4'h0, 1'b0, 1, 1, -1, "after_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
